// File: rtl/ram_block_loader_pkg.sv
// ---------------------------------------------------------------------------
// Module : ram_block_loader_pkg
// Desc   : State encoding and RAM sizing shared by the ROM/loader family.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_block_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned ram_size(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_block_sdp.sv
// ---------------------------------------------------------------------------
// Module : ram_block_sdp
// Desc   : Simple dual-port block RAM, read-first, registered enable-gated read.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_block_sdp #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [RAM_ADDR_BITS-1:0] waddr,
  input  logic [RAM_WIDTH-1:0]     wdata,
  input  logic                     re,
  input  logic [RAM_ADDR_BITS-1:0] raddr,
  output logic [RAM_WIDTH-1:0]     rdata
);

  (* ram_style = "block" *)
  logic [RAM_WIDTH-1:0] r_mem [0:(2**RAM_ADDR_BITS)-1];

  logic [RAM_WIDTH-1:0] r_rdata;

  // Array contents are never reset so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ram_block_loader.sv
// ---------------------------------------------------------------------------
// Module : ram_block_loader
// Desc   : Loads a valid/ready word stream into block RAM at consecutive
//          addresses; exposes a ROM-compatible one-cycle read port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_block_loader
  import ram_block_loader_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  input  logic                     wr_valid,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic                     done,
  output logic                     full,
  output logic [RAM_ADDR_BITS:0]   count,
  input  logic [RAM_ADDR_BITS-1:0] rd_addr,
  input  logic                     rd_en,
  output logic [RAM_WIDTH-1:0]     rd_data
);

  localparam int unsigned              RAM_SIZE   = ram_size(RAM_ADDR_BITS);
  localparam logic [RAM_ADDR_BITS-1:0] C_LAST_PTR = RAM_ADDR_BITS'(RAM_SIZE - 1);
  localparam logic [RAM_ADDR_BITS:0]   C_FULL_CNT = (RAM_ADDR_BITS+1)'(RAM_SIZE);

  state_t                   r_state;
  logic [RAM_ADDR_BITS-1:0] r_ptr;
  logic [RAM_ADDR_BITS:0]   r_count;
  logic                     r_ready;
  logic                     r_done;
  logic                     r_full;

  logic                     w_beat;
  logic                     w_final_beat;
  logic [RAM_ADDR_BITS:0]   w_count_nxt;

  assign w_beat       = wr_valid && r_ready;
  assign w_final_beat = w_beat && (wr_last || (r_ptr == C_LAST_PTR));
  assign w_count_nxt  = r_count + 1'b1;

  // Handshake flags are registered alongside the state so no output
  // depends combinationally on an input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= w_count_nxt;
          end
          if (w_final_beat) begin
            r_state <= ST_DONE;
            r_ready <= 1'b0;
            r_done  <= 1'b1;
            r_full  <= (w_count_nxt == C_FULL_CNT);
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  ram_block_sdp #(
    .RAM_WIDTH    (RAM_WIDTH),
    .RAM_ADDR_BITS(RAM_ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (w_beat),
    .waddr(r_ptr),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign wr_ready = r_ready;
  assign done     = r_done;
  assign full     = r_full;
  assign count    = r_count;

endmodule

`default_nettype wire
